// File: rtl/rv_pkg.sv
// Shared RV32I core definitions: data width, canonical nop, fetch FSM states.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Next-PC selection for the fetch stage.
// Ports:
//   pc         in   current program counter
//   PC_src     in   1 = branch/jump target, 0 = sequential
//   pc_target  in   target computed downstream
//   next_pc    out  selected next program counter
//   misaligned out  next_pc is not word aligned
module next_pc_sel
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            PC_src,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  always_comb begin
    next_pc    = PC_src ? pc_target : pc + XLEN'(4);
    misaligned = |next_pc[1:0];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word at a time over a
// req/gnt/rvalid handshake and presents it to decode until retired.
// Ports:
//   clk, rst       core clock, asynchronous active-high reset
//   PC_src         next-PC select from control (used on retire only)
//   pc_target      branch/jump target
//   advance        downstream retires the current instruction
//   imem_req       fetch request valid
//   imem_addr      fetch address (= pc)
//   imem_gnt       memory accepts the request
//   imem_rvalid    response valid
//   imem_rdata     response word
//   instr          held instruction
//   pc, pc_plus4   address of instr and its successor
//   instr_valid    instr/pc valid for decode
//   fetch_err      sticky error: misaligned next PC or memory timeout
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PC_src,
  input  logic [XLEN-1:0] pc_target,
  input  logic            advance,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            instr_valid,
  output logic            fetch_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  fetch_state_e    state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [XLEN-1:0] pc_nx, instr_nx;
  logic            req_nx, valid_nx, err_nx;
  logic [XLEN-1:0] sel_pc;
  logic            sel_mis;

  next_pc_sel u_next_pc_sel (
    .pc         (pc),
    .PC_src     (PC_src),
    .pc_target  (pc_target),
    .next_pc    (sel_pc),
    .misaligned (sel_mis)
  );

  assign imem_addr = pc;
  assign pc_plus4  = pc + XLEN'(4);

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= REQ;
      cnt         <= '0;
      pc          <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      pc          <= pc_nx;
      instr       <= instr_nx;
      instr_valid <= valid_nx;
      imem_req    <= req_nx;
      fetch_err   <= err_nx;
    end
  end

  // Next state; req/valid are registered from the next state so they line up
  // with the state they describe. The first REQ cycle after reset has req low,
  // so a grant is only honoured while req is actually asserted.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pc_nx    = pc;
    instr_nx = instr;
    err_nx   = fetch_err;

    unique case (state)
      REQ: begin
        if (imem_req && imem_gnt) begin
          state_nx = WAIT;
          cnt_nx   = '0;
        end
      end
      WAIT: begin
        // rvalid takes priority over the timeout compare
        if (imem_rvalid) begin
          instr_nx = imem_rdata;
          state_nx = VALID;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          err_nx   = 1'b1;
          state_nx = HALT;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      VALID: begin
        if (advance) begin
          if (sel_mis) begin
            err_nx   = 1'b1;
            state_nx = HALT;
          end else begin
            pc_nx    = sel_pc;
            state_nx = REQ;
          end
        end
      end
      HALT:    state_nx = HALT;
      default: state_nx = HALT;
    endcase

    req_nx   = (state_nx == REQ);
    valid_nx = (state_nx == VALID);
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: retire-vector table, randomized
// memory latencies against a PC-sequence model, and hand-written corner cases.
module tb_instr_fetch_unit;

  localparam int unsigned TIMEOUT  = 16;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, PC_src, advance;
  logic [31:0] pc_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instr, pc, pc_plus4;
  logic        instr_valid, fetch_err;

  int errors = 0;
  int checks = 0;

  bit          auto_mode = 1'b0;
  bit          rnd_mode  = 1'b0;
  logic        m_gnt = 1'b0, m_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic        r_gnt = 1'b0, r_rvalid = 1'b0;
  logic [31:0] r_rdata = 32'h0;

  assign imem_gnt    = auto_mode ? r_gnt    : m_gnt;
  assign imem_rvalid = auto_mode ? r_rvalid : m_rvalid;
  assign imem_rdata  = auto_mode ? r_rdata  : m_rdata;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .PC_src      (PC_src),
    .pc_target   (pc_target),
    .advance     (advance),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err)
  );

  // Memory content: a fixed scramble of the address
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (instr_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: instr_valid=%b after 64 cycles, expected 1", instr_valid);
    end
  endtask

  // Auto-responding memory: grants after gnt_lat cycles, answers rv_lat
  // cycles into WAIT (rv_lat = 0 means the first WAIT cycle).
  initial begin : responder
    bit          pend  = 1'b0;
    bit          gnt_q = 1'b0;
    int          wcnt = 0, gcnt = 0, gnt_lat = 0, rv_lat = 0;
    logic [31:0] pend_addr = 32'h0, addr_q = 32'h0;
    forever begin
      @(negedge clk);
      if (gnt_q) begin
        pend      = 1'b1;
        wcnt      = 0;
        pend_addr = addr_q;
        if (rnd_mode)
          rv_lat = ($urandom_range(0, 7) == 0) ? int'(TIMEOUT - 1) : int'($urandom_range(0, 4));
        else
          rv_lat = 0;
      end
      gnt_q    = 1'b0;
      r_gnt    = 1'b0;
      r_rvalid = 1'b0;
      if (rst || !auto_mode) begin
        pend = 1'b0;
        gcnt = 0;
      end else if (pend) begin
        if (wcnt == rv_lat) begin
          r_rvalid = 1'b1;
          r_rdata  = word_of(pend_addr);
          pend     = 1'b0;
        end else begin
          wcnt++;
        end
      end else if (imem_req) begin
        if (gcnt >= gnt_lat) begin
          r_gnt   = 1'b1;
          gnt_q   = 1'b1;
          addr_q  = imem_addr;
          gcnt    = 0;
          gnt_lat = rnd_mode ? int'($urandom_range(0, 3)) : 0;
        end else begin
          gcnt++;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        src;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[7];

  initial begin : main
    bit          ok;
    logic [31:0] model_pc;
    logic [31:0] p;
    int          hold;

    // PC sequence starting from pc = 0; includes the 0xFFFFFFFC wrap and a
    // misaligned target that must be ignored because PC_src = 0.
    vecs[0] = '{1'b0, 32'hDEAD_0000, 32'h0000_0004};
    vecs[1] = '{1'b1, 32'h0000_0010, 32'h0000_0010};
    vecs[2] = '{1'b0, 32'h0000_0000, 32'h0000_0014};
    vecs[3] = '{1'b1, 32'h0000_0040, 32'h0000_0040};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[5] = '{1'b0, 32'h1234_5677, 32'h0000_0000};
    vecs[6] = '{1'b1, 32'h0000_0100, 32'h0000_0100};

    rst = 1'b1; advance = 1'b0; PC_src = 1'b0; pc_target = 32'h0;
    tick(); tick();
    check("rst_pc", pc, RESET_PC);
    check("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
    check("rst_instr", instr, NOP);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_req", imem_req, 1'b0);
    check("rst_err", fetch_err, 1'b0);

    // First fetch: grant in the REQ cycle, data in the first WAIT cycle
    rst = 1'b0;
    tick();
    check("f1_req", imem_req, 1'b1);
    check("f1_addr", imem_addr, RESET_PC);
    check("f1_valid0", instr_valid, 1'b0);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0050_0093;
    check("f1_req_wait", imem_req, 1'b0);
    check("f1_valid1", instr_valid, 1'b0);
    tick();
    m_rvalid = 1'b0;
    check("f1_valid", instr_valid, 1'b1);
    check("f1_instr", instr, 32'h0050_0093);
    check("f1_pc", pc, 32'h0);
    check("f1_pc_plus4", pc_plus4, 32'h4);

    // Retire table with zero-latency memory
    auto_mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      advance = 1'b1; PC_src = vecs[i].src; pc_target = vecs[i].tgt;
      tick();
      advance = 1'b0;
      check("tbl_req", imem_req, 1'b1);
      check("tbl_addr", imem_addr, vecs[i].exp_pc);
      check("tbl_valid_drop", instr_valid, 1'b0);
      wait_valid(ok);
      if (ok) begin
        check("tbl_instr", instr, word_of(vecs[i].exp_pc));
        check("tbl_pc", pc, vecs[i].exp_pc);
        check("tbl_pc_plus4", pc_plus4, vecs[i].exp_pc + 32'd4);
        check("tbl_err", fetch_err, 1'b0);
      end
    end

    // Randomized latencies and retire decisions
    rnd_mode = 1'b1;
    model_pc = vecs[6].exp_pc;
    for (int n = 0; n < 40; n++) begin
      hold = int'($urandom_range(0, 3));
      for (int h = 0; h < hold; h++) begin
        tick();
        check("rnd_hold_instr", instr, word_of(model_pc));
        check("rnd_hold_valid", instr_valid, 1'b1);
      end
      PC_src    = 1'($urandom_range(0, 1));
      pc_target = $urandom & 32'hFFFF_FFFC;
      model_pc  = PC_src ? pc_target : model_pc + 32'd4;
      advance   = 1'b1;
      tick();
      advance = 1'b0;
      check("rnd_addr", imem_addr, model_pc);
      wait_valid(ok);
      if (ok) begin
        check("rnd_instr", instr, word_of(model_pc));
        check("rnd_pc", pc, model_pc);
        check("rnd_pc_plus4", pc_plus4, model_pc + 32'd4);
        check("rnd_err", fetch_err, 1'b0);
      end
    end
    rnd_mode  = 1'b0;
    auto_mode = 1'b0;

    // Grant held low for 5 cycles, then no response until timeout
    p = model_pc + 32'd4;
    advance = 1'b1; PC_src = 1'b0;
    tick();
    advance = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_req", imem_req, 1'b1);
      check("stall_addr", imem_addr, p);
      check("stall_err", fetch_err, 1'b0);
      tick();
    end
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    check("to_req_wait", imem_req, 1'b0);
    for (int k = 1; k < 16; k++) begin
      check("to_no_err_early", fetch_err, 1'b0);
      tick();
    end
    check("to_no_err_last", fetch_err, 1'b0);
    tick();
    check("to_err", fetch_err, 1'b1);
    check("to_valid", instr_valid, 1'b0);
    check("to_req", imem_req, 1'b0);
    check("to_pc", pc, p);
    m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D;
    tick();
    m_rvalid = 1'b0;
    tick(); tick();
    check("halt_valid", instr_valid, 1'b0);
    check("halt_req", imem_req, 1'b0);
    check("halt_err", fetch_err, 1'b1);

    // rvalid in the last WAIT cycle wins over the timeout
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    m_rvalid = 1'b1; m_rdata = 32'h00A0_0113;
    tick();
    m_rvalid = 1'b0;
    check("edge_valid", instr_valid, 1'b1);
    check("edge_err", fetch_err, 1'b0);
    check("edge_instr", instr, 32'h00A0_0113);

    // Misaligned branch target
    advance = 1'b1; PC_src = 1'b1; pc_target = 32'h0000_0042;
    tick();
    advance = 1'b0;
    check("mis_err", fetch_err, 1'b1);
    check("mis_pc", pc, RESET_PC);
    check("mis_valid", instr_valid, 1'b0);
    check("mis_req", imem_req, 1'b0);
    tick(); tick();
    check("mis_req_hold", imem_req, 1'b0);

    // Reset pulsed in WAIT, late response afterwards must be dropped
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rw_pc", pc, RESET_PC);
    check("rw_req", imem_req, 1'b0);
    check("rw_err", fetch_err, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    m_rvalid = 1'b1; m_rdata = 32'hBAD0_BAD0;
    check("rw_new_req", imem_req, 1'b1);
    check("rw_new_addr", imem_addr, RESET_PC);
    tick();
    m_rvalid = 1'b0;
    check("rw_late_valid", instr_valid, 1'b0);
    check("rw_late_instr", instr, NOP);
    check("rw_still_req", imem_req, 1'b1);
    m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h0050_0093;
    tick();
    m_rvalid = 1'b0;
    check("rw_refetch_valid", instr_valid, 1'b1);
    check("rw_refetch_instr", instr, 32'h0050_0093);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the control unit in the RV32I core.
- Holds the PC and issues word requests to instruction memory over a request/grant/response handshake.
- Captures the returned word, presents it with pc/pc_plus4 to decode and control, and selects the next PC from PC_src and the branch/jump target once the current instruction retires.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles in WAIT before fetch_err is raised.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- PC_src  in  1  from control unit: 1 = take pc_target, 0 = pc+4. Sampled only on retire.
- pc_target  in  32  branch/jump target computed downstream.
- advance  in  1  downstream has consumed the current instruction (retire).
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word address, equal to pc.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  held instruction, feeds the control unit's instr input.
- pc  out  32  address of instr.
- pc_plus4  out  32  pc + 4, used for the jal writeback path.
- instr_valid  out  1  instr/pc are valid for decode.
- fetch_err  out  1  sticky error flag: misaligned target or memory timeout.

Behaviour:
- Reset values (asynchronous): pc = RESET_PC, instr = 32'h0000_0013 (nop), instr_valid = 0, imem_req = 0, fetch_err = 0, state = REQ, timeout counter = 0.
- FSM states: REQ, WAIT, VALID, HALT.
- REQ
  - imem_req = 1, imem_addr = pc.
  - imem_gnt = 1 -> WAIT, counter cleared. Otherwise stay in REQ holding addr stable.
- WAIT
  - imem_req = 0; counter increments each cycle.
  - imem_rvalid = 1 -> instr <= imem_rdata, go to VALID.
  - Counter reaches TIMEOUT-1 without rvalid -> fetch_err <= 1, go to HALT.
  - rvalid in the same cycle as the timeout compare wins: data is captured and no error is raised.
- VALID
  - instr_valid = 1; instr, pc and pc_plus4 are held stable.
  - advance = 1 computes next = PC_src ? pc_target : pc + 4.
    - next[1:0] != 0 -> fetch_err <= 1, go to HALT, pc unchanged.
    - Otherwise pc <= next, instr_valid <= 0, go to REQ.
  - advance = 0 -> stay.
- HALT
  - Terminal state: instr_valid = 0, imem_req = 0.
  - Exited only by rst.
- Latency
  - Minimum fetch is 3 cycles, from REQ entry to instr_valid: grant in the REQ cycle, rvalid in the first WAIT cycle.
  - Retire to the next request is 1 cycle.
- Arithmetic: pc + 4 wraps modulo 2^32; 32'hFFFF_FFFC + 4 = 0, no error.
- imem_rvalid and imem_rdata outside WAIT are ignored.
- rst asserted mid-operation (any state) returns to the reset values immediately. Any outstanding memory response is dropped because rvalid outside WAIT is ignored.
- pc_plus4 is combinational from pc.

Decomposition:
- Shared package rv_pkg:
  - fetch state enum (REQ, WAIT, VALID, HALT).
  - NOP_INSTR = 32'h0000_0013.
  - XLEN = 32.
- One natural sub-module: next_pc_sel, combinational. Inputs pc, PC_src, pc_target. Outputs next pc and misaligned flag.

Test Plan:
- Reset release with RESET_PC = 0: mem grants immediately and returns 32'h00500093 the next cycle -> instr_valid high on cycle 3, instr = 32'h00500093, pc = 0, pc_plus4 = 4.
- advance with PC_src = 0 at pc = 0x10 -> next imem_addr = 0x14. Then PC_src = 1 with pc_target = 0x40 -> imem_addr = 0x40.
- imem_gnt held low for 5 cycles -> imem_req and imem_addr stay stable at pc through all 5 cycles, no error.
- No rvalid for TIMEOUT = 16 cycles in WAIT -> fetch_err = 1, instr_valid = 0, imem_req stays 0 until rst.
- advance with PC_src = 1 and pc_target = 0x42 -> fetch_err = 1, pc stays at its old value, HALT.
- rst pulsed while in WAIT, then a late rvalid arrives -> late data ignored, pc = RESET_PC, fresh request issued.
